branch_predictor: RTL and testbench

- Dynamic conditional-branch direction predictor in the fetch stage; drives the branch_taken prediction consumed by the execute-stage branch resolver.
- Bimodal table of 2-bit saturating counters, indexed by PC, read combinationally each fetch.
- Trained by the resolver's outcome a few cycles later; also keeps branch and misprediction statistics counters.

---
 rtl/branch_pkg.sv | 29 ++
 rtl/sat_counter_stat.sv | 23 ++
 rtl/branch_predictor.sv | 83 ++++++++
 tb/tb_branch_predictor.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared definitions for the branch predictor and execute-stage resolver:
// 2-bit counter states, counter update helper and branch func3 encodings.
package branch_pkg;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    localparam logic [1:0] CTR_RESET = WNT;

    // Conditional-branch func3 encodings used by the resolver.
    typedef enum logic [2:0] {
        BrBeq  = 3'b000,
        BrBne  = 3'b001,
        BrBlt  = 3'b100,
        BrBge  = 3'b101,
        BrBltu = 3'b110,
        BrBgeu = 3'b111
    } branch_func3_e;

    function automatic logic [1:0] sat_update(input logic [1:0] counter, input logic taken);
        if (taken) begin
            return (counter == ST) ? ST : counter + 2'd1;
        end
        return (counter == SNT) ? SNT : counter - 2'd1;
    endfunction

endpackage

// File: rtl/sat_counter_stat.sv
// Saturating statistics counter: counts enabled cycles, holds at all-ones.
module sat_counter_stat #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/branch_predictor.sv
// Bimodal 2-bit-counter branch direction predictor with branch/mispredict stats.
// Define GSHARE_EN to XOR the PC index with a resolved-outcome global history.
module branch_predictor
    import branch_pkg::*;
#(
    parameter int unsigned INDEX_BITS = 6,
    parameter int unsigned PC_W       = 32,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [PC_W-1:0]       if_pc,
    output logic                  pred_taken,
    output logic [INDEX_BITS-1:0] pred_index,
    input  logic                  upd_valid,
    input  logic [INDEX_BITS-1:0] upd_index,
    input  logic                  upd_pred_taken,
    input  logic                  upd_mispredict,
    output logic [CNT_W-1:0]      stat_branches,
    output logic [CNT_W-1:0]      stat_mispredicts
);

    localparam int unsigned ENTRIES = 1 << INDEX_BITS;

    logic [1:0]            tbl_q [ENTRIES];
    logic [INDEX_BITS-1:0] pc_index;
    logic                  actual;
    logic                  unused_pc;

    assign pc_index  = if_pc[INDEX_BITS+1:2];
    assign unused_pc = ^{if_pc[PC_W-1:INDEX_BITS+2], if_pc[1:0]};
    assign actual    = upd_pred_taken ^ upd_mispredict;

`ifdef GSHARE_EN
    logic [INDEX_BITS-1:0] ghr_q;

    // History only advances on resolved branches, so no repair is needed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ghr_q <= '0;
        end else if (upd_valid) begin
            ghr_q <= {ghr_q[INDEX_BITS-2:0], actual};
        end
    end

    assign pred_index = pc_index ^ ghr_q;
`else
    assign pred_index = pc_index;
`endif

    // Read is combinational off the registered table, so a same-cycle update is
    // only visible on the following cycle.
    assign pred_taken = tbl_q[pred_index][1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                tbl_q[i] <= CTR_RESET;
            end
        end else if (upd_valid) begin
            tbl_q[upd_index] <= sat_update(tbl_q[upd_index], actual);
        end
    end

    sat_counter_stat #(
        .CNT_W (CNT_W)
    ) u_stat_branches (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (upd_valid),
        .count (stat_branches)
    );

    sat_counter_stat #(
        .CNT_W (CNT_W)
    ) u_stat_mispredicts (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (upd_valid & upd_mispredict),
        .count (stat_mispredicts)
    );

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed vector table, GSHARE_EN
// history sequence when that build is selected, and a randomized model run.
module tb_branch_predictor;

    localparam int IB = 6;
    localparam int PW = 32;
    localparam int CW = 32;
    localparam longint STAT_MAX = (64'd1 << CW) - 1;

    logic          clk;
    logic          rst_n;
    logic [PW-1:0] if_pc;
    logic          pred_taken;
    logic [IB-1:0] pred_index;
    logic          upd_valid;
    logic [IB-1:0] upd_index;
    logic          upd_pred_taken;
    logic          upd_mispredict;
    logic [CW-1:0] stat_branches;
    logic [CW-1:0] stat_mispredicts;

    int n_vec = 0;
    int n_err = 0;

    branch_predictor #(
        .INDEX_BITS (IB),
        .PC_W       (PW),
        .CNT_W      (CW)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .if_pc            (if_pc),
        .pred_taken       (pred_taken),
        .pred_index       (pred_index),
        .upd_valid        (upd_valid),
        .upd_index        (upd_index),
        .upd_pred_taken   (upd_pred_taken),
        .upd_mispredict   (upd_mispredict),
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          rst_n;
        logic [PW-1:0] pc;
        logic          uv;
        logic [IB-1:0] ui;
        logic          up;
        logic          um;
        logic          exp_taken;
        logic [IB-1:0] exp_index;
        longint        exp_br;
        longint        exp_mis;
    } vec_t;

    vec_t vecs[$];

    // Reference model state
    int     m_ctr[1 << IB];
    longint m_br;
    longint m_mis;
    int     m_ghr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [PW-1:0] pc, input logic uv,
                         input logic [IB-1:0] ui, input logic up, input logic um);
        rst_n          = r;
        if_pc          = pc;
        upd_valid      = uv;
        upd_index      = ui;
        upd_pred_taken = up;
        upd_mispredict = um;
    endtask

    function automatic vec_t mk(input logic r, input logic [PW-1:0] pc, input logic uv,
                                input logic [IB-1:0] ui, input logic up, input logic um,
                                input logic et, input logic [IB-1:0] ei,
                                input longint eb, input longint em);
        vec_t v;
        v.rst_n = r;  v.pc = pc;  v.uv = uv;  v.ui = ui;  v.up = up;  v.um = um;
        v.exp_taken = et;  v.exp_index = ei;  v.exp_br = eb;  v.exp_mis = em;
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < (1 << IB); k++) m_ctr[k] = 1;
        m_br  = 0;
        m_mis = 0;
        m_ghr = 0;
    endtask

    task automatic model_step(input logic r, input logic uv, input int ui,
                              input logic up, input logic um);
        int act;
        if (!r) begin
            model_reset();
        end else if (uv) begin
            act = (up != um) ? 1 : 0;
            if (act == 1) m_ctr[ui] = (m_ctr[ui] == 3) ? 3 : m_ctr[ui] + 1;
            else          m_ctr[ui] = (m_ctr[ui] == 0) ? 0 : m_ctr[ui] - 1;
            if (m_br < STAT_MAX) m_br++;
            if (um && m_mis < STAT_MAX) m_mis++;
            m_ghr = ((m_ghr << 1) | act) % (1 << IB);
        end
    endtask

    initial begin
        drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;

`ifndef GSHARE_EN
        // rst, pc, uv, ui, up, um | taken, index, branches, mispredicts
        vecs.push_back(mk(1, 32'h100, 0, 0, 0, 0, 0, 6'h00, 0, 0));
        vecs.push_back(mk(1, 32'h014, 1, 5, 0, 1, 0, 6'h05, 0, 0));
        vecs.push_back(mk(1, 32'h014, 1, 5, 0, 1, 1, 6'h05, 1, 1));
        vecs.push_back(mk(1, 32'h014, 1, 5, 0, 1, 1, 6'h05, 2, 2));
        vecs.push_back(mk(1, 32'h014, 1, 5, 1, 0, 1, 6'h05, 3, 3));
        vecs.push_back(mk(1, 32'h014, 1, 5, 1, 1, 1, 6'h05, 4, 3));
        vecs.push_back(mk(1, 32'h014, 1, 5, 1, 1, 1, 6'h05, 5, 4));
        vecs.push_back(mk(1, 32'h014, 0, 5, 0, 0, 0, 6'h05, 6, 5));
        vecs.push_back(mk(1, 32'h01C, 1, 7, 0, 1, 0, 6'h07, 6, 5));
        vecs.push_back(mk(1, 32'h01C, 0, 0, 0, 0, 1, 6'h07, 7, 6));
        vecs.push_back(mk(1, 32'h01C, 0, 7, 0, 0, 1, 6'h07, 7, 6));
        vecs.push_back(mk(0, 32'h01C, 1, 7, 0, 1, 1, 6'h07, 7, 6));
        vecs.push_back(mk(1, 32'h01C, 0, 0, 0, 0, 0, 6'h07, 0, 0));
        vecs.push_back(mk(0, 32'h00C, 1, 3, 0, 1, 0, 6'h03, 0, 0));
        vecs.push_back(mk(1, 32'h00C, 0, 0, 0, 0, 0, 6'h03, 0, 0));
        vecs.push_back(mk(1, 32'h00C, 1, 3, 1, 0, 0, 6'h03, 0, 0));
        vecs.push_back(mk(1, 32'h00C, 0, 0, 0, 0, 1, 6'h03, 1, 0));
        vecs.push_back(mk(1, 32'h10F, 0, 0, 0, 0, 1, 6'h03, 1, 0));

        foreach (vecs[i]) begin
            drive(vecs[i].rst_n, vecs[i].pc, vecs[i].uv, vecs[i].ui, vecs[i].up, vecs[i].um);
            #1;
            check($sformatf("vec%0d pred_taken", i), 64'(pred_taken), 64'(vecs[i].exp_taken));
            check($sformatf("vec%0d pred_index", i), 64'(pred_index), 64'(vecs[i].exp_index));
            check($sformatf("vec%0d stat_branches", i), 64'(stat_branches), vecs[i].exp_br);
            check($sformatf("vec%0d stat_mispredicts", i), 64'(stat_mispredicts),
                  vecs[i].exp_mis);
            @(posedge clk);
            #1;
        end
`else
        // History: taken, taken, not-taken -> 6'b000110
        drive(1'b1, 32'h0, 1'b1, 6'd0, 1'b0, 1'b1);
        @(posedge clk); #1;
        drive(1'b1, 32'h0, 1'b1, 6'd1, 1'b1, 1'b0);
        @(posedge clk); #1;
        drive(1'b1, 32'h0, 1'b1, 6'd2, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(1'b1, 32'h0, 1'b0, 6'd0, 1'b0, 1'b0);
        #1;
        check("gshare pc0 pred_index", 64'(pred_index), 64'h06);
        drive(1'b1, 32'h18, 1'b0, 6'd0, 1'b0, 1'b0);
        #1;
        check("gshare pc18 pred_index", 64'(pred_index), 64'h00);
        check("gshare stat_branches", 64'(stat_branches), 64'd3);
        check("gshare stat_mispredicts", 64'(stat_mispredicts), 64'd1);
        @(posedge clk); #1;
`endif

        // Randomized run against the reference model
        drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        for (int c = 0; c < 3000; c++) begin
            logic [PW-1:0] pc;
            logic          r;
            logic          uv;
            logic [IB-1:0] ui;
            logic          up;
            logic          um;
            int            idx;
            r  = ($urandom_range(0, 49) != 0);
            pc = $urandom;
            pc[7:2] = 6'($urandom_range(0, 7));
            uv = ($urandom_range(0, 2) != 0);
            ui = 6'($urandom_range(0, 7));
            up = 1'($urandom_range(0, 1));
            um = 1'($urandom_range(0, 1));
            drive(r, pc, uv, ui, up, um);
            #1;
`ifdef GSHARE_EN
            idx = ((int'(pc) >>> 2) & ((1 << IB) - 1)) ^ m_ghr;
`else
            idx = (int'(pc) >>> 2) & ((1 << IB) - 1);
`endif
            check($sformatf("rand%0d pred_index", c), 64'(pred_index), 64'(idx));
            check($sformatf("rand%0d pred_taken", c), 64'(pred_taken),
                  64'((m_ctr[idx] >= 2) ? 1 : 0));
            check($sformatf("rand%0d stat_branches", c), 64'(stat_branches), m_br);
            check($sformatf("rand%0d stat_mispredicts", c), 64'(stat_mispredicts), m_mis);
            model_step(r, uv, int'(ui), up, um);
            @(posedge clk);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
